// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Width of a counter that must hold the values 0..len inclusive.
  function automatic int unsigned cnt_w(input int unsigned len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Configuration word stream (valid/ready) feeding the chain loader.
interface ccff_chain_loader_if #(
  parameter int unsigned WORD_W = 8
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// Holds one configuration word and shifts it out LSB-first; accepts the next
// word on the last shifting cycle so a continuous stream has no bubble.
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = cnt_w(CHAIN_LEN)
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  i_load,
  input  logic [CNT_W-1:0]      i_bit_cnt,
  ccff_chain_loader_if.slave    bus,
  output logic                  o_head,
  output logic                  o_shift
);

  logic [WORD_W-1:0] r_word;
  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W:0]    w_committed;
  logic [CNT_W:0]    w_room;
  logic [CNT_W-1:0]  w_new_rem;
  logic              w_accept;

  // Bits already shifted plus bits still waiting in the shifter.
  assign w_committed = {1'b0, i_bit_cnt} + {1'b0, r_rem};
  assign w_room      = (CNT_W+1)'(CHAIN_LEN) - w_committed;
  assign w_new_rem   = (32'(w_room) > WORD_W) ? CNT_W'(WORD_W) : CNT_W'(w_room);

  assign o_shift = i_load && (r_rem != '0);
  assign o_head  = o_shift & r_word[0];

  assign bus.word_ready = i_load
                       && (w_committed < (CNT_W+1)'(CHAIN_LEN))
                       && ((r_rem == '0) || (r_rem == CNT_W'(1)));
  assign w_accept = bus.word_ready && bus.word_valid;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_word <= '0;
      r_rem  <= '0;
    end else if (w_accept) begin
      r_word <= bus.word_data;
      r_rem  <= w_new_rem;
    end else if (o_shift) begin
      r_word <= r_word >> 1;
      r_rem  <= r_rem - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Transmit end of the ccff_head -> ccff_tail configuration chain: serializes
// words into the chain and optionally recirculates it to check a ones-count.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8
) (
  input  logic               prog_clk,
  input  logic               prog_reset,
  input  logic               start,
  input  logic               verify_en,
  ccff_chain_loader_if.slave bus,
  output logic               ccff_head,
  input  logic               ccff_tail,
  output logic               cfg_clk_en,
  output logic               busy,
  output logic               done,
  output logic               verify_err
);

  localparam int unsigned CNT_W = cnt_w(CHAIN_LEN);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_pop_load;
  logic [CNT_W-1:0] r_pop_tail;
  logic [CNT_W-1:0] r_vcnt;
  logic             r_verify_en;
  logic             r_busy;
  logic             r_done;
  logic             r_verify_err;

  logic             w_in_load;
  logic             w_shift;
  logic             w_head;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic [CNT_W-1:0] w_pop_tail_nxt;
  logic             w_v_last;

  // Reset gates the chain interface in the same cycle it is asserted.
  assign w_in_load = (r_state == LOAD) && !prog_reset;

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W),
    .CNT_W     (CNT_W)
  ) u_ser (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .i_load     (w_in_load),
    .i_bit_cnt  (r_bit_cnt),
    .bus        (bus),
    .o_head     (w_head),
    .o_shift    (w_shift)
  );

  assign w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(w_shift);
  assign w_pop_tail_nxt = r_pop_tail + CNT_W'(ccff_tail);
  assign w_v_last       = (r_vcnt == CNT_W'(CHAIN_LEN - 1));

  always_ff @(posedge prog_clk) begin
    if (prog_reset) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // Next state plus the chain-side combinational outputs.
  always_comb begin
    w_next     = r_state;
    ccff_head  = 1'b0;
    cfg_clk_en = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = LOAD;
      end
      LOAD: begin
        ccff_head  = w_head;
        cfg_clk_en = w_shift;
        if (w_bit_cnt_nxt == CNT_W'(CHAIN_LEN)) w_next = r_verify_en ? VERIFY : DONE;
      end
      VERIFY: begin
        ccff_head  = ccff_tail;
        cfg_clk_en = 1'b1;
        if (w_v_last) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (prog_reset) begin
      ccff_head  = 1'b0;
      cfg_clk_en = 1'b0;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_bit_cnt    <= '0;
      r_pop_load   <= '0;
      r_pop_tail   <= '0;
      r_vcnt       <= '0;
      r_verify_en  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_verify_err <= 1'b0;
    end else begin
      r_busy <= (w_next == LOAD) || (w_next == VERIFY);
      r_done <= (w_next == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_verify_en  <= verify_en;
            r_bit_cnt    <= '0;
            r_pop_load   <= '0;
            r_pop_tail   <= '0;
            r_vcnt       <= '0;
            r_verify_err <= 1'b0;
          end
        end
        LOAD: begin
          if (w_shift && (r_bit_cnt != CNT_W'(CHAIN_LEN))) begin
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_pop_load <= r_pop_load + CNT_W'(w_head);
          end
        end
        VERIFY: begin
          r_vcnt     <= r_vcnt + CNT_W'(1);
          r_pop_tail <= w_pop_tail_nxt;
          if (w_v_last) r_verify_err <= (w_pop_tail_nxt != r_pop_load);
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign verify_err = r_verify_err;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: a 3-DFF and a 20-DFF chain model driven by two loaders.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start3, ven3, head3, tail3, en3, busy3, done3, err3;
  logic start20, ven20, head20, tail20, en20, busy20, done20, err20;
  logic [2:0]  mem3  = '0;
  logic [19:0] mem20 = '0;
  int stuck20 = 0;
  int n_pass = 0;
  int n_total = 0;
  int en_c, bub_c, acc_c, dn_c, lat_c;
  logic err0_c;

  ccff_chain_loader_if #(.WORD_W(8)) bus3 ();
  ccff_chain_loader_if #(.WORD_W(8)) bus20 ();

  ccff_chain_loader #(.CHAIN_LEN(3), .WORD_W(8)) u_dut3 (
    .prog_clk(clk), .prog_reset(rst), .start(start3), .verify_en(ven3), .bus(bus3),
    .ccff_head(head3), .ccff_tail(tail3), .cfg_clk_en(en3), .busy(busy3),
    .done(done3), .verify_err(err3));

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut20 (
    .prog_clk(clk), .prog_reset(rst), .start(start20), .verify_en(ven20), .bus(bus20),
    .ccff_head(head20), .ccff_tail(tail20), .cfg_clk_en(en20), .busy(busy20),
    .done(done20), .verify_err(err20));

  // Chain models: head enters mem[0], tail leaves from the top DFF.
  always @(posedge clk) if (en3)  mem3  <= {mem3[1:0], head3};
  always @(posedge clk) if (en20) mem20 <= {mem20[18:0], head20};
  assign tail3  = mem3[2];
  assign tail20 = (stuck20 == 1) ? 1'b0 : (stuck20 == 2) ? 1'b1 : mem20[19];

  // One 20-bit operation with words A5,3C,FF then a spare 00 always offered.
  task automatic run20(input bit ver, input int hold_cycles, input int abort_at, input bit poke,
                       output int en_cnt, output int bubbles, output int acc,
                       output int done_cnt, output int done_lat, output logic err_at_start);
    logic [7:0] words [4];
    int first_en, last_en, done_cyc, idx, hold;
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    first_en = -1; last_en = -1; done_cyc = -1; idx = 0; hold = 0;
    en_cnt = 0; bubbles = 0; acc = 0; done_cnt = 0; done_lat = -1; err_at_start = 1'bx;
    start20 = 1'b1; ven20 = ver;
    @(posedge clk); #1;
    start20 = 1'b0; ven20 = 1'b0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      bus20.word_valid = (hold == 0);
      bus20.word_data  = words[idx];
      start20 = poke && (en_cnt == 5);
      ven20   = start20;
      #1;
      if (cyc == 0) err_at_start = err20;
      if (bus20.word_ready && bus20.word_valid) begin
        acc++;
        if (idx < 3) idx++;
        if (acc == 1) hold = hold_cycles;
      end else if (hold > 0) hold--;
      if (en20) begin
        if (first_en < 0) first_en = cyc;
        else if (last_en != cyc - 1) bubbles += cyc - 1 - last_en;
        last_en = cyc;
        en_cnt++;
      end
      if (done20) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (abort_at > 0 && en20 && en_cnt == abort_at) begin
        rst = 1'b1;
        bus20.word_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(posedge clk); #1;
    end
    start20 = 1'b0; ven20 = 1'b0;
    bus20.word_valid = 1'b0;
    if (done_cyc >= 0) done_lat = done_cyc - last_en;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start3 = 0; ven3 = 0; bus3.word_valid = 0; bus3.word_data = '0;
    start20 = 0; ven20 = 0; bus20.word_valid = 0; bus20.word_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (busy20 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy20); else n_pass++;
    n_total++; if (done20 !== 1'b0) $display("FAIL rst_done: got %b want 0", done20); else n_pass++;
    n_total++; if (err20 !== 1'b0) $display("FAIL rst_err: got %b want 0", err20); else n_pass++;
    n_total++; if (en20 !== 1'b0) $display("FAIL rst_en: got %b want 0", en20); else n_pass++;
    n_total++; if (head20 !== 1'b0) $display("FAIL rst_head: got %b want 0", head20); else n_pass++;
    n_total++; if (bus20.word_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus20.word_ready); else n_pass++;
    n_total++; if ({busy3, done3, err3, en3} !== 4'b0) $display("FAIL rst_dut3: got %b want 0000", {busy3, done3, err3, en3}); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_chain3();
    int en_cnt = 0, acc = 0, dn = 0, first_en = -1, last_en = -1, done_cyc = -1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    n_total++; if (busy3 !== 1'b1) $display("FAIL c3_busy: got %b want 1", busy3); else n_pass++;
    bus3.word_data = 8'h05; bus3.word_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (bus3.word_ready && bus3.word_valid) acc++;
      if (en3) begin
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        en_cnt++;
      end
      if (done3) begin
        dn++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    bus3.word_valid = 1'b0;
    n_total++; if (en_cnt !== 3) $display("FAIL c3_en_cnt: got %0d want 3", en_cnt); else n_pass++;
    n_total++; if (last_en - first_en !== 2) $display("FAIL c3_en_span: got %0d want 2", last_en - first_en); else n_pass++;
    n_total++; if (acc !== 1) $display("FAIL c3_accepts: got %0d want 1", acc); else n_pass++;
    n_total++; if (mem3 !== 3'b101) $display("FAIL c3_mem: got %b want 101", mem3); else n_pass++;
    n_total++; if (dn !== 1) $display("FAIL c3_done_cnt: got %0d want 1", dn); else n_pass++;
    n_total++; if (done_cyc - last_en !== 1) $display("FAIL c3_done_lat: got %0d want 1", done_cyc - last_en); else n_pass++;
    n_total++; if (busy3 !== 1'b0) $display("FAIL c3_idle_busy: got %b want 0", busy3); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run20(1'b0, 0, 0, 1'b0, en_c, bub_c, acc_c, dn_c, lat_c, err0_c);
    n_total++; if (en_c !== 20) $display("FAIL b2b_en_cnt: got %0d want 20", en_c); else n_pass++;
    n_total++; if (bub_c !== 0) $display("FAIL b2b_bubbles: got %0d want 0", bub_c); else n_pass++;
    n_total++; if (acc_c !== 3) $display("FAIL b2b_accepts: got %0d want 3", acc_c); else n_pass++;
    n_total++; if (mem20 !== 20'hA53CF) $display("FAIL b2b_mem: got %h want a53cf", mem20); else n_pass++;
    n_total++; if (dn_c !== 1) $display("FAIL b2b_done_cnt: got %0d want 1", dn_c); else n_pass++;
    n_total++; if (lat_c !== 1) $display("FAIL b2b_done_lat: got %0d want 1", lat_c); else n_pass++;
  endtask

  task automatic test_gap();
    mem20 = '0;
    run20(1'b0, 12, 0, 1'b0, en_c, bub_c, acc_c, dn_c, lat_c, err0_c);
    n_total++; if (en_c !== 20) $display("FAIL gap_en_cnt: got %0d want 20", en_c); else n_pass++;
    n_total++; if (bub_c !== 5) $display("FAIL gap_bubbles: got %0d want 5", bub_c); else n_pass++;
    n_total++; if (mem20 !== 20'hA53CF) $display("FAIL gap_mem: got %h want a53cf", mem20); else n_pass++;
  endtask

  task automatic test_verify_ok();
    run20(1'b1, 0, 0, 1'b0, en_c, bub_c, acc_c, dn_c, lat_c, err0_c);
    n_total++; if (en_c !== 40) $display("FAIL vok_en_cnt: got %0d want 40", en_c); else n_pass++;
    n_total++; if (bub_c !== 0) $display("FAIL vok_bubbles: got %0d want 0", bub_c); else n_pass++;
    n_total++; if (mem20 !== 20'hA53CF) $display("FAIL vok_mem: got %h want a53cf", mem20); else n_pass++;
    n_total++; if (err20 !== 1'b0) $display("FAIL vok_err: got %b want 0", err20); else n_pass++;
    n_total++; if (lat_c !== 1) $display("FAIL vok_done_lat: got %0d want 1", lat_c); else n_pass++;
  endtask

  task automatic test_verify_fault();
    stuck20 = 1;
    run20(1'b1, 0, 0, 1'b0, en_c, bub_c, acc_c, dn_c, lat_c, err0_c);
    stuck20 = 0;
    n_total++; if (err20 !== 1'b1) $display("FAIL vsa0_err: got %b want 1", err20); else n_pass++;
    n_total++; if (dn_c !== 1) $display("FAIL vsa0_done_cnt: got %0d want 1", dn_c); else n_pass++;
    stuck20 = 2;
    run20(1'b1, 0, 0, 1'b0, en_c, bub_c, acc_c, dn_c, lat_c, err0_c);
    stuck20 = 0;
    n_total++; if (err0_c !== 1'b0) $display("FAIL vsa1_err_clr_on_start: got %b want 0", err0_c); else n_pass++;
    n_total++; if (err20 !== 1'b1) $display("FAIL vsa1_err: got %b want 1", err20); else n_pass++;
    run20(1'b1, 0, 0, 1'b0, en_c, bub_c, acc_c, dn_c, lat_c, err0_c);
    n_total++; if (err0_c !== 1'b0) $display("FAIL vre_err_clr_on_start: got %b want 0", err0_c); else n_pass++;
    n_total++; if (err20 !== 1'b0) $display("FAIL vre_err: got %b want 0", err20); else n_pass++;
  endtask

  task automatic test_reset_mid();
    mem20 = '0;
    run20(1'b0, 0, 8, 1'b0, en_c, bub_c, acc_c, dn_c, lat_c, err0_c);
    n_total++; if (en_c !== 8) $display("FAIL rmid_en_before: got %0d want 8", en_c); else n_pass++;
    n_total++; if (busy20 !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy20); else n_pass++;
    n_total++; if (en20 !== 1'b0) $display("FAIL rmid_en: got %b want 0", en20); else n_pass++;
    n_total++; if (bus20.word_ready !== 1'b0) $display("FAIL rmid_ready: got %b want 0", bus20.word_ready); else n_pass++;
    run20(1'b0, 0, 0, 1'b0, en_c, bub_c, acc_c, dn_c, lat_c, err0_c);
    n_total++; if (en_c !== 20) $display("FAIL rmid_reload_en: got %0d want 20", en_c); else n_pass++;
    n_total++; if (mem20 !== 20'hA53CF) $display("FAIL rmid_reload_mem: got %h want a53cf", mem20); else n_pass++;
  endtask

  task automatic test_start_busy();
    mem20 = '0;
    run20(1'b0, 0, 0, 1'b1, en_c, bub_c, acc_c, dn_c, lat_c, err0_c);
    n_total++; if (en_c !== 20) $display("FAIL sbusy_en_cnt: got %0d want 20", en_c); else n_pass++;
    n_total++; if (bub_c !== 0) $display("FAIL sbusy_bubbles: got %0d want 0", bub_c); else n_pass++;
    n_total++; if (mem20 !== 20'hA53CF) $display("FAIL sbusy_mem: got %h want a53cf", mem20); else n_pass++;
    n_total++; if (lat_c !== 1) $display("FAIL sbusy_done_lat: got %0d want 1", lat_c); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_chain3();
    test_back_to_back();
    test_gap();
    test_verify_ok();
    test_verify_fault();
    test_reset_mid();
    test_start_busy();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Bitstream driver for the configuration-chain memories: the transmit end of the ccff_head -> ccff_tail shift chain.
- Accepts configuration words over a valid/ready stream and serializes them LSB-first onto ccff_head.
- Emits a chain clock-enable so the chain shifts only when a valid bit is present.
- Optionally recirculates the loaded chain through ccff_tail and checks a ones-count signature to confirm chain integrity.

Parameters:
- CHAIN_LEN, 64: total number of DFFs in the chain (>=1).
- WORD_W, 8: input word width (>=1).
- CNT_W, $clog2(CHAIN_LEN+1): width of the bit and popcount counters (derived; do not override).

Ports:
- prog_clk, input, 1: configuration clock; the only clock.
- prog_reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request to begin a load; honoured only in IDLE.
- verify_en, input, 1: sampled with start; 1 = run the VERIFY pass after LOAD.
- word_data, input, WORD_W: configuration word; bit 0 is shifted first.
- word_valid, input, 1: word_data is valid.
- word_ready, output, 1: loader accepts the word this cycle.
- ccff_head, output, 1: serial bit into the chain head.
- ccff_tail, input, 1: serial bit from the chain tail.
- cfg_clk_en, output, 1: chain shift enable (drives the chain clock gate); the chain captures ccff_head at every prog_clk edge where it is 1.
- busy, output, 1: high in LOAD and VERIFY.
- done, output, 1: one-cycle pulse when the operation completes.
- verify_err, output, 1: signature mismatch; sticky until the next accepted start or reset.

Behaviour:
- Reset (synchronous): state=IDLE; all counters, the shifter and the signature registers are cleared.
- Output values in reset: word_ready=0, ccff_head=0, cfg_clk_en=0, busy=0, done=0, verify_err=0.
- Reset mid-operation: cfg_clk_en is 0 from the next cycle on. Chain contents are then undefined, and software must reload.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE -> LOAD on start. This captures verify_en, clears bit_cnt, pop_load, pop_tail and verify_err. A start in any other state is ignored.
- LOAD shifter: holds the current word plus a remaining-bit count. ccff_head = shifter bit 0. cfg_clk_en = (remaining != 0).
- LOAD shift: on each enabled cycle, shift right, bit_cnt += 1, and pop_load += ccff_head.
- word_ready = LOAD && bit_cnt + (remaining) < CHAIN_LEN && (remaining == 0 || (remaining == 1 && cfg_clk_en)). Continuous word_valid therefore gives gapless shifting with no bubble at word boundaries.
- Accepted word: loads the shifter with remaining = min(WORD_W, CHAIN_LEN - bits already committed). Excess upper bits of the final word are discarded.
- Underflow stall: word_valid low while the shifter is empty forces cfg_clk_en=0, and the chain holds its state. There is no timeout.
- LOAD exit: the cycle bit_cnt reaches CHAIN_LEN, the next state is VERIFY if verify_en was captured, else DONE. No extra words are accepted once the final bit is committed.
- VERIFY runs exactly CHAIN_LEN cycles. cfg_clk_en=1, ccff_head = ccff_tail (combinational loopback, so contents are preserved), pop_tail += ccff_tail.
- VERIFY end: set verify_err = (pop_tail != pop_load), then go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=0 in DONE.
- Bit placement: after load, the first bit shifted sits at the tail-end DFF. The last bit shifted sits in mem_out[0].
- Latency, gapless stream: LOAD lasts CHAIN_LEN cycles after the first accept. VERIFY adds CHAIN_LEN cycles. DONE is 1 cycle.
- Counter rules: counters saturate at CHAIN_LEN and are never wrapped. Popcounts are CNT_W wide, so no overflow is possible.

Decomposition:
- Shared package ccff_pkg holds:
  - the state enum {IDLE, LOAD, VERIFY, DONE};
  - a cnt_w(len) constant function.
- Sub-module ccff_word_serializer: word register, remaining count, ready logic and ccff_head.
- Top level holds the FSM, bit_cnt, the popcounts and verify.

Test Plan:
- CHAIN_LEN=3, WORD_W=8, chain = 3-DFF mem model, verify_en=0: start, then word 0x05 valid -> cfg_clk_en high exactly 3 cycles; mem_out = {[0]=1, [1]=0, [2]=1}; done pulses 1 cycle after the 3rd shift; bits 3..7 are ignored.
- CHAIN_LEN=20, WORD_W=8: words 0xA5, 0x3C, 0xFF presented back-to-back -> 20 consecutive enable cycles with no gap; third word truncated to 4 bits (1111); pop_load = 4+4+4 = 12.
- Same config, with word_valid dropped for 5 cycles after the first word -> cfg_clk_en=0 for those 5 cycles; final chain contents are identical to the gapless run.
- verify_en=1, fault-free chain -> VERIFY lasts CHAIN_LEN cycles; chain contents are unchanged afterwards; verify_err=0.
- verify_en=1 with ccff_tail stuck-at-0 and pop_load=12 -> verify_err=1 at done; it clears on the next start.
- prog_reset asserted mid-LOAD (bit_cnt=7) -> next cycle: busy=0, cfg_clk_en=0, word_ready=0; start is then honoured and the full load repeats.
- A start pulse while busy has no effect on the state or counters.
